// File: rtl/csa_serial_pkg.sv
`default_nettype none
// ============================================================
// csa_serial_pkg : shared types/constants for csa_serial_add
// Rev 1.0
// ============================================================
package csa_serial_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_8_ci.sv
`default_nettype none
// ============================================================
// csa_8_ci : 8-bit carry-select adder with carry-in
// Rev 1.0
// ============================================================
module csa_8_ci (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  // Upper nibble is precomputed for both carry values; the low carry picks one.
  assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
  assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

  assign sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign cout = lo[4] ? hi1[4] : hi0[4];

endmodule
`default_nettype wire

// File: rtl/csa_serial_add.sv
`default_nettype none
// ============================================================
// csa_serial_add : byte-serial wide adder, valid/ready in/out
// Optional subtract mode via CSA_SERIAL_SUB_EN.  Rev 1.0
// ============================================================
module csa_serial_add
  import csa_serial_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NBYTES*BYTE_W-1:0] a,
  input  logic [NBYTES*BYTE_W-1:0] b,
`ifdef CSA_SERIAL_SUB_EN
  input  logic                     sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NBYTES*BYTE_W-1:0] sum,
  output logic                     carry
);

  localparam int W     = NBYTES * BYTE_W;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [IDX_W-1:0]   idx;
  logic               creg;
  logic [BYTE_W-1:0]  a_byte;
  logic [BYTE_W-1:0]  b_byte;
  logic [BYTE_W-1:0]  s_byte;
  logic               c_byte;
  logic               accept;
  logic               last;
  logic               sub_mode;

`ifdef CSA_SERIAL_SUB_EN
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST_IDX);
  assign a_byte = a_r[idx*BYTE_W +: BYTE_W];
  assign b_byte = b_r[idx*BYTE_W +: BYTE_W];

  csa_8_ci u_csa (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (creg),
    .sum  (s_byte),
    .cout (c_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Subtraction is a + ~b + 1: B is inverted at capture and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      creg  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r  <= a;
            b_r  <= sub_mode ? ~b : b;
            idx  <= '0;
            creg <= sub_mode;
          end
        end
        RUN: begin
          sum[idx*BYTE_W +: BYTE_W] <= s_byte;
          creg <= c_byte;
          if (last) carry <= c_byte;
          else      idx   <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csa_serial_add.sv
`default_nettype none
// ============================================================
// tb_csa_serial_add : directed bench with transaction-level model
// Rev 1.0
// ============================================================
module tb_csa_serial_add;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv0 = 0, or0 = 0;
  logic        ir0, ov0, c0;
  logic [31:0] a0 = 0, b0 = 0, s0;
  logic        iv1 = 0, or1 = 0;
  logic        ir1, ov1, c1;
  logic [7:0]  a1 = 0, b1 = 0, s1;
`ifdef CSA_SERIAL_SUB_EN
  logic        sub0 = 0;
`endif

  csa_serial_add #(.NBYTES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
`ifdef CSA_SERIAL_SUB_EN
    .sub(sub0),
`endif
    .out_valid(ov0), .out_ready(or0), .sum(s0), .carry(c0)
  );

  csa_serial_add #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
`ifdef CSA_SERIAL_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction model: an accepted op completes NBYTES edges later with
  // result a + b (or a + ~b + 1), held until the consumer takes it.
  int          rem   [2];
  bit          mval  [2];
  logic [32:0] pend  [2];
  logic [32:0] held  [2];
  bit          started = 0;

  always @(posedge clk) begin
    logic [32:0] av, bv, mask;
    bit ivk, ork, sk;
    int wk, nk;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        av = {1'b0, a0}; bv = {1'b0, b0}; ivk = iv0; ork = or0; wk = 32; nk = 4;
`ifdef CSA_SERIAL_SUB_EN
        sk = sub0;
`else
        sk = 1'b0;
`endif
      end else begin
        av = {25'd0, a1}; bv = {25'd0, b1}; ivk = iv1; ork = or1; wk = 8; nk = 1; sk = 1'b0;
      end
      mask = (33'd1 << wk) - 33'd1;
      if (!rst_n) begin
        rem[k] = 0; mval[k] = 0; held[k] = '0;
      end else if (mval[k]) begin
        if (ork) mval[k] = 0;
      end else if (rem[k] > 0) begin
        rem[k] = rem[k] - 1;
        if (rem[k] == 0) begin mval[k] = 1; held[k] = pend[k]; end
      end else if (ivk) begin
        pend[k] = av + (sk ? (~bv & mask) : bv) + {32'd0, sk};
        rem[k]  = nk;
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ready0",  ir0, (rem[0] == 0 && !mval[0]));
      chk("m_out_valid0", ov0, mval[0]);
      if (mval[0]) begin
        chk("m_sum0", s0, held[0][31:0]);
        chk("m_carry0", c0, held[0][32]);
      end
      chk("m_in_ready1",  ir1, (rem[1] == 0 && !mval[1]));
      chk("m_out_valid1", ov1, mval[1]);
      if (mval[1]) begin
        chk("m_sum1", s1, held[1][7:0]);
        chk("m_carry1", c1, held[1][8]);
      end
    end
  end

  // Entered at posedge+2; leaves at posedge+2 just after the accept edge.
  task automatic do_op0(input logic [31:0] aa, input logic [31:0] bb, input bit s);
    iv0 = 1; a0 = aa; b0 = bb;
`ifdef CSA_SERIAL_SUB_EN
    sub0 = s;
`endif
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir0) break;
    end
    chk("accept_ready0", ir0, 1);
    @(posedge clk); #2;
    iv0 = 0; a0 = 32'hDEADBEEF; b0 = 32'hCAFEF00D;
`ifdef CSA_SERIAL_SUB_EN
    sub0 = !s;
`endif
  endtask

  // Counts negedges from the accept edge until out_valid; NBYTES edges => NBYTES+1.
  task automatic wait_valid0(output int lat);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (ov0) break;
    end
    chk("valid_seen0", ov0, 1);
  endtask

  task automatic take0;
    or0 = 1;
    @(posedge clk); #2;
    or0 = 0;
  endtask

  int lat;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready",  ir0, 1);
    chk("rst_out_valid", ov0, 0);
    chk("rst_sum",       s0, 0);
    chk("rst_carry",     c0, 0);
    chk("rst_in_ready1", ir1, 1);
    @(posedge clk); #2;

    do_op0(32'h000000FF, 32'h00000001, 0);
    wait_valid0(lat);
    chk("latency4", lat, 5);
    chk("ff_plus_1_sum", s0, 32'h00000100);
    chk("ff_plus_1_carry", c0, 0);
    take0();

    do_op0(32'hFFFFFFFF, 32'h00000001, 0);
    wait_valid0(lat);
    chk("ripple_sum", s0, 32'h00000000);
    chk("ripple_carry", c0, 1);
    take0();

    do_op0(32'h00001234, 32'h00004321, 0);
    wait_valid0(lat);
    chk("bp_first_sum", s0, 32'h00005555);
    iv0 = 1; a0 = 32'hAAAAAAAA; b0 = 32'h11111111;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", ov0, 1);
      chk("bp_ready", ir0, 0);
      chk("bp_sum",   s0, 32'h00005555);
    end
    or0 = 1;
    @(posedge clk); #2;
    or0 = 0;
    @(negedge clk);
    chk("bp_idle_ready", ir0, 1);
    chk("bp_idle_valid", ov0, 0);
    @(posedge clk); #2;
    iv0 = 0;
    wait_valid0(lat);
    chk("bp_second_sum", s0, 32'hBBBBBBBB);
    chk("bp_second_carry", c0, 0);
    take0();

    do_op0(32'h12345678, 32'h11111111, 0);
    @(posedge clk); #2;
    rst_n = 0;
    @(posedge clk); #2;
    rst_n = 1;
    @(negedge clk);
    chk("abort_valid", ov0, 0);
    chk("abort_ready", ir0, 1);
    chk("abort_sum",   s0, 0);
    @(posedge clk); #2;
    do_op0(32'h12345678, 32'h11111111, 0);
    wait_valid0(lat);
    chk("redo_sum", s0, 32'h23456789);
    chk("redo_carry", c0, 0);
    take0();

`ifdef CSA_SERIAL_SUB_EN
    do_op0(32'd5, 32'd7, 1);
    wait_valid0(lat);
    chk("sub_5m7_sum", s0, 32'hFFFFFFFE);
    chk("sub_5m7_carry", c0, 0);
    take0();
    do_op0(32'd7, 32'd5, 1);
    wait_valid0(lat);
    chk("sub_7m5_sum", s0, 32'h00000002);
    chk("sub_7m5_carry", c0, 1);
    take0();
`endif

    iv1 = 1; a1 = 8'h80; b1 = 8'h80;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir1) break;
    end
    chk("accept_ready1", ir1, 1);
    @(posedge clk); #2;
    iv1 = 0; a1 = 8'h3C; b1 = 8'h5A;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (ov1) break;
    end
    chk("latency1", lat, 2);
    chk("n1_sum", s1, 8'h00);
    chk("n1_carry", c1, 1);
    or1 = 1;
    @(posedge clk); #2;
    or1 = 0;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/csa_serial_add.md
Name: csa_serial_add

Overview:
- Multi-cycle wide adder built around an 8-bit carry-select byte datapath.
- Accepts two NBYTES-wide operands over a valid/ready handshake.
- Adds them one byte per cycle, LSB first, with the carry held in a register between bytes.
- Returns the registered sum and carry-out on a valid/ready output handshake.
- Sits upstream of the byte adder: sequences operands into it and consumes its results.

Parameters:
NBYTES, 4, operand width in bytes (legal 1..16); operand width W = 8*NBYTES

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands
a  input  W  operand A
b  input  W  operand B
out_valid  output  1  sum/carry valid
out_ready  input  1  consumer accepts result
sum  output  W  registered result
carry  output  1  carry out of MSB byte

Behaviour:
- Single clock. Reset is synchronous and active-low: when rst_n=0 at a rising clk edge, the block is reset.
- Reset values:
  - state=IDLE
  - out_valid=0
  - sum=0, carry=0
  - internal carry register=0, byte index=0
  - in_ready=1 (combinational from state==IDLE)
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a and b into operand registers, set idx=0 and creg=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle compute {c,s} = a_r[idx] + b_r[idx] + creg, as an 8-bit add with carry-in.
  - Write s into result byte idx; creg<=c.
  - If idx==NBYTES-1: carry<=c, go to DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and carry are held stable.
  - On out_ready: go to IDLE, out_valid<=0.
- Latency: operands accepted at edge 0 → out_valid=1 after edge NBYTES (NBYTES RUN cycles).
- Throughput: at most one operation per NBYTES+2 cycles. No accept in the same cycle as result handoff.
- sum is meaningful only while out_valid=1. During RUN it updates byte-by-byte.
- Width rules:
  - All arithmetic is unsigned, modulo 2^W; the carry output holds bit W.
  - idx width = max(1, $clog2(NBYTES)).
- NBYTES=1: exactly one RUN cycle.
- in_valid while not ready is ignored. Upstream must hold operands until in_ready.
- out_ready while out_valid=0 is ignored.
- Reset mid-operation (RUN or DONE) aborts the operation and discards it; all values return to reset values. No partial result is ever flagged valid.
- Operands are sampled only at accept. Changes to a/b afterwards have no effect.

Optional Feature:
- Macro: CSA_SERIAL_SUB_EN.
- With the macro defined:
  - Extra input port "sub" (1 bit), sampled at accept.
  - sub=1: B is inverted byte-wise, and creg is initialised to 1, giving a-b mod 2^W.
  - carry=1 means no borrow (a>=b).
  - sub=0: identical to plain add.
- Without the macro: no sub port; add only; creg initialised to 0.

Decomposition:
- Package csa_serial_pkg:
  - state enum type (IDLE, RUN, DONE)
  - byte width constant BYTE_W=8
  - function for idx width
- Sub-module csa_8_ci: 8-bit carry-select adder with carry-in.
  - Two 4-bit halves; upper half computed for both carry cases, selected by the lower carry.
  - Ports: a[7:0], b[7:0], cin, sum[7:0], cout.
  - Combinational.
  - csa_serial_add instantiates exactly one.

Test Plan:
- Reset hold 2 cycles, release → in_ready=1, out_valid=0, sum=0, carry=0.
- NBYTES=4, a=0x000000FF, b=0x00000001, accept at cycle 0 → out_valid at cycle 4, sum=0x00000100, carry=0; in_ready=0 cycles 1-4.
- a=0xFFFFFFFF, b=0x00000001 → sum=0x00000000, carry=1 (full carry ripple across all bytes).
- Back-pressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands → sum/carry/out_valid stable, in_ready=0, new operands not taken; out_ready=1 → IDLE next cycle, then new operands accepted.
- Reset asserted on 2nd RUN cycle of a=0x12345678, b=0x11111111 → next cycle IDLE, out_valid=0, sum=0; subsequent op a=0x12345678, b=0x11111111 → sum=0x23456789, carry=0.
- CSA_SERIAL_SUB_EN: a=5, b=7, sub=1 → sum=0xFFFFFFFE, carry=0; a=7, b=5, sub=1 → sum=0x00000002, carry=1; NBYTES=1 variant a=0x80, b=0x80, sub=0 → sum=0x00, carry=1, out_valid after 1 cycle.
